// File: rtl/dff_arb_pkg.sv
// Shared definitions for the DFF-bank arbiter: FSM encodings and width helpers.
package dff_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Width needed to index n items; never narrower than one bit.
  function automatic int arb_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PTR_W_DFLT = arb_width(4);
  localparam int CNT_W_DFLT = arb_width(16);

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int cand;

  always_comb begin
    sel_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        sel_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of a shared WIDTH-bit register; only the granted requester may load it,
// and a hold limit forces release so no requester starves the others.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr_en,
  input  logic [NUM_REQ*WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           q,
  output logic                       busy,
  output logic                       timeout
);

  localparam int PTR_W = arb_width(NUM_REQ);
  localparam int CNT_W = arb_width(MAX_HOLD);

  logic               state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0] pick_sel;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               owner_req;
  logic               wr_acc;
  logic [PTR_W-1:0]   ptr_after_owner;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (pick_sel),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign owner_req       = req[owner_q];
  assign wr_acc          = (state_q == ST_GRANT) && owner_req && wr_en[owner_q];
  assign ptr_after_owner = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    data_d  = wr_acc ? wr_data[int'(owner_q)*WIDTH +: WIDTH] : data_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        state_d = ST_GRANT;
        gnt_d   = pick_sel;
        owner_d = pick_idx;
        cnt_d   = '0;
      end
    end else begin
      // Both release paths hand the pointer to the requester after the owner.
      if (!owner_req || (cnt_q == CNT_W'(MAX_HOLD - 1))) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_after_owner;
        tmo_d   = owner_req;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign q       = data_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with hand-computed expected values.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  dff_bank_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .MAX_HOLD (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    int seg, pos;
    reset   = 1'b0;
    req     = '0;
    wr_en   = '0;
    wr_data = '0;
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout, 0);
    reset = 1'b1;
    tick();

    // Two requesters from pointer 0; then hand-off after one idle cycle.
    req = 4'b0110;
    tick();
    chk("rr_first_gnt", gnt, 4'b0010);
    chk("rr_first_busy", busy, 1);
    req = 4'b0100;
    tick();
    chk("rel_gnt", gnt, 0);
    chk("rel_busy", busy, 0);
    chk("rel_tmo", timeout, 0);
    tick();
    chk("rr_second_gnt", gnt, 4'b0100);

    // Owner write wins; non-owner write ignored; no write in release cycle.
    req   = 4'b1100;
    wr_en = 4'b1100;
    wr_data[16 +: 8] = 8'hA5;
    wr_data[24 +: 8] = 8'h3C;
    tick();
    chk("own_write", q, 8'hA5);
    req = 4'b1000;
    wr_data[16 +: 8] = 8'h77;
    tick();
    chk("rel_nowrite_q", q, 8'hA5);
    chk("rel_nowrite_gnt", gnt, 0);
    tick();
    chk("gnt3", gnt, 4'b1000);
    chk("gnt3_q", q, 8'hA5);
    req   = '0;
    wr_en = '0;
    tick();
    chk("gnt3_rel", gnt, 0);

    // Strobes with nobody requesting do nothing.
    wr_en   = 4'b1111;
    wr_data = 32'h11111111;
    tick();
    tick();
    chk("idle_wr_q", q, 8'hA5);
    chk("idle_wr_gnt", gnt, 0);
    chk("idle_wr_busy", busy, 0);
    wr_en = '0;

    // Single requester held 40 cycles: 16 granted, forced release, 1 idle, repeat.
    req = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      if (k == 16) begin
        wr_en = 4'b0001;
        wr_data[0 +: 8] = 8'hC3;
      end
      tick();
      if (k == 16) wr_en = '0;
      chk($sformatf("hold_gnt_%0d", k), gnt, ((k % 17) != 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("hold_tmo_%0d", k), timeout, ((k % 17) == 0) ? 1 : 0);
      if (k == 17) chk("forced_rel_write", q, 8'hC3);
    end
    req = '0;
    tick();
    chk("hold_drop_gnt", gnt, 0);
    chk("hold_drop_tmo", timeout, 0);

    // Async reset mid-grant with q=5A (pointer is 1 here).
    req   = 4'b0010;
    wr_en = 4'b0010;
    wr_data[8 +: 8] = 8'h5A;
    tick();
    tick();
    chk("pre_rst_q", q, 8'h5A);
    chk("pre_rst_gnt", gnt, 4'b0010);
    #3;
    reset = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_busy", busy, 0);
    chk("async_q", q, 0);
    chk("async_tmo", timeout, 0);
    req   = '0;
    wr_en = '0;
    tick();
    reset = 1'b1;
    tick();

    // All four requesting: 0,1,2,3,0 with 16-cycle grants and one-cycle gaps.
    req = 4'b1111;
    for (int k = 1; k <= 85; k++) begin
      tick();
      seg   = (k - 1) / 17;
      pos   = (k - 1) % 17;
      exp_g = (pos < 16) ? (4'b0001 << (seg % 4)) : 4'b0000;
      chk($sformatf("all_gnt_%0d", k), gnt, exp_g);
      chk($sformatf("all_tmo_%0d", k), timeout, (pos == 16) ? 1 : 0);
    end
    req = '0;
    tick();
    chk("all_end_q", q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
